// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decodes RV32I(+M) in ID and registers the control word into
// the ID/EX register. Handles the valid/ready handshake, load-use bubbles,
// multi-cycle divide occupancy, illegal-opcode pulses and branch flush.
module ctrl_pipe_unit #(
  parameter int ALUCTRL_WIDTH = 5,
  parameter bit ENABLE_M      = 1'b1,
  parameter int DIV_CYCLES    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [31:0]              id_instr,
  output logic                     id_ready,
  input  logic                     ex_ready,
  input  logic                     flush,
  output logic                     ex_valid,
  output logic                     ex_reg_write,
  output logic                     ex_mem_read,
  output logic                     ex_mem_write,
  output logic                     ex_branch,
  output logic [ALUCTRL_WIDTH-1:0] ex_alu_ctrl,
  output logic [1:0]               ex_pc_src,
  output logic [2:0]               ex_imm_src,
  output logic [4:0]               ex_rd,
  output logic [4:0]               ex_rs1,
  output logic [4:0]               ex_rs2,
  output logic                     ex_muldiv,
  output logic                     load_use_stall,
  output logic                     illegal
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] pc_src;
    logic [2:0] imm_src;
    logic [4:0] alu;
    logic       muldiv;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ex_fields_t;

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  ex_fields_t  raw_fields_s;
  ex_fields_t  dec_fields_s;
  ex_fields_t  div_hold_s;
  logic        dec_illegal_s;
  logic        rs1_raw_s;
  logic        rs2_raw_s;
  logic        rs1_used_s;
  logic        rs2_used_s;
  logic        is_div_s;
  logic        div_busy_s;
  logic        load_use_s;
  logic        id_ready_s;
  logic        accept_s;
  logic [ALUCTRL_WIDTH-1:0] alu_ext_s;

  ex_fields_t       ex_fields_r;
  logic             ex_valid_r;
  logic             illegal_r;
  logic [CNT_W-1:0] div_cnt_r;

  assign opcode_s = id_instr[6:0];
  assign funct3_s = id_instr[14:12];
  assign funct7_s = id_instr[31:25];

  // Raw decode of the ID instruction into a control word and rs-usage flags.
  always_comb begin
    raw_fields_s     = '0;
    dec_illegal_s    = 1'b0;
    rs1_raw_s        = 1'b0;
    rs2_raw_s        = 1'b0;
    raw_fields_s.rd  = id_instr[11:7];
    raw_fields_s.rs1 = id_instr[19:15];
    raw_fields_s.rs2 = id_instr[24:20];
    case (opcode_s)
      OP_R: begin
        raw_fields_s.reg_write = 1'b1;
        raw_fields_s.alu       = {funct7_s[0], funct7_s[5], funct3_s};
        rs1_raw_s              = 1'b1;
        rs2_raw_s              = 1'b1;
        if (funct7_s == 7'b0000001) begin
          if (ENABLE_M) begin
            raw_fields_s.muldiv = 1'b1;
          end else begin
            dec_illegal_s = 1'b1;
          end
        end else begin
          raw_fields_s.muldiv = 1'b0;
        end
      end
      OP_IALU: begin
        raw_fields_s.reg_write = 1'b1;
        raw_fields_s.imm_src   = 3'b000;
        raw_fields_s.alu       = {1'b0, funct7_s[5] & (funct3_s == 3'b101), funct3_s};
        rs1_raw_s              = 1'b1;
      end
      OP_LOAD: begin
        raw_fields_s.reg_write = 1'b1;
        raw_fields_s.mem_read  = 1'b1;
        raw_fields_s.imm_src   = 3'b000;
        rs1_raw_s              = 1'b1;
      end
      OP_STORE: begin
        raw_fields_s.mem_write = 1'b1;
        raw_fields_s.imm_src   = 3'b001;
        rs1_raw_s              = 1'b1;
        rs2_raw_s              = 1'b1;
      end
      OP_BRANCH: begin
        raw_fields_s.branch  = 1'b1;
        raw_fields_s.imm_src = 3'b010;
        raw_fields_s.pc_src  = 2'b01;
        raw_fields_s.alu     = {2'b01, funct3_s};
        rs1_raw_s            = 1'b1;
        rs2_raw_s            = 1'b1;
      end
      OP_JAL: begin
        raw_fields_s.reg_write = 1'b1;
        raw_fields_s.imm_src   = 3'b011;
        raw_fields_s.pc_src    = 2'b01;
      end
      OP_JALR: begin
        raw_fields_s.reg_write = 1'b1;
        raw_fields_s.imm_src   = 3'b000;
        raw_fields_s.pc_src    = 2'b10;
        rs1_raw_s              = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        raw_fields_s.reg_write = 1'b1;
        raw_fields_s.imm_src   = 3'b100;
      end
      default: begin
        dec_illegal_s = 1'b1;
      end
    endcase
  end

  // An undecodable instruction carries no control and no register dependency.
  assign dec_fields_s = dec_illegal_s ? ex_fields_t'('0) : raw_fields_s;
  assign rs1_used_s   = rs1_raw_s & ~dec_illegal_s;
  assign rs2_used_s   = rs2_raw_s & ~dec_illegal_s;
  assign is_div_s     = dec_fields_s.muldiv & funct3_s[2];

  // While a divide occupies EX its write enable and muldiv flag stay low so
  // the hold cycles look like bubbles; both are raised on release.
  always_comb begin
    div_hold_s           = dec_fields_s;
    div_hold_s.reg_write = 1'b0;
    div_hold_s.muldiv    = 1'b0;
  end

  assign div_busy_s = (div_cnt_r != '0);
  assign load_use_s = id_valid & ex_valid_r & ex_fields_r.mem_read & (ex_fields_r.rd != 5'd0)
                    & ((rs1_used_s & (ex_fields_r.rd == raw_fields_s.rs1))
                     | (rs2_used_s & (ex_fields_r.rd == raw_fields_s.rs2)));
  // During a flush ID is always acknowledged so upstream discards its slot.
  assign id_ready_s = flush | (~load_use_s & ~div_busy_s & (~ex_valid_r | ex_ready));
  assign accept_s   = id_valid & id_ready_s & ~flush;

  // ID/EX register update: flush, then accept, then divide release, then drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r  <= 1'b0;
      ex_fields_r <= '0;
      div_cnt_r   <= '0;
      illegal_r   <= 1'b0;
    end else if (flush) begin
      ex_valid_r  <= 1'b0;
      ex_fields_r <= '0;
      div_cnt_r   <= '0;
      illegal_r   <= 1'b0;
    end else if (accept_s) begin
      illegal_r <= dec_illegal_s;
      if (dec_illegal_s) begin
        ex_valid_r  <= 1'b0;
        ex_fields_r <= '0;
      end else if (is_div_s) begin
        ex_valid_r  <= 1'b0;
        ex_fields_r <= div_hold_s;
        div_cnt_r   <= DIV_LOAD;
      end else begin
        ex_valid_r  <= 1'b1;
        ex_fields_r <= dec_fields_s;
      end
    end else begin
      illegal_r <= 1'b0;
      if (div_busy_s) begin
        div_cnt_r <= div_cnt_r - CNT_W'(1);
        if (div_cnt_r == CNT_W'(1)) begin
          ex_valid_r            <= 1'b1;
          ex_fields_r.reg_write <= 1'b1;
          ex_fields_r.muldiv    <= 1'b1;
        end
      end else if (ex_ready) begin
        ex_valid_r  <= 1'b0;
        ex_fields_r <= '0;
      end
    end
  end

  // Zero-extend the 5-bit ALU code to the configured output width.
  always_comb begin
    alu_ext_s      = '0;
    alu_ext_s[4:0] = ex_fields_r.alu;
  end

  assign id_ready       = id_ready_s;
  assign load_use_stall = load_use_s;
  assign ex_valid       = ex_valid_r;
  assign ex_reg_write   = ex_fields_r.reg_write;
  assign ex_mem_read    = ex_fields_r.mem_read;
  assign ex_mem_write   = ex_fields_r.mem_write;
  assign ex_branch      = ex_fields_r.branch;
  assign ex_alu_ctrl    = alu_ext_s;
  assign ex_pc_src      = ex_fields_r.pc_src;
  assign ex_imm_src     = ex_fields_r.imm_src;
  assign ex_rd          = ex_fields_r.rd;
  assign ex_rs1         = ex_fields_r.rs1;
  assign ex_rs2         = ex_fields_r.rs2;
  assign ex_muldiv      = ex_fields_r.muldiv;
  assign illegal        = illegal_r;

endmodule
